fft_peak_detector: RTL and testbench

//  Sits directly downstream of the 16-point FFT stage of the frequency analysis system.

---
 rtl/freq_analysis_pkg.sv | 35 +++
 rtl/fft_peak_detector_if.sv | 30 +++
 rtl/bin_mag_sq.sv | 28 ++
 rtl/fft_peak_detector.sv | 132 +++++++++++++
 tb/tb_fft_peak_detector.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_analysis_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : freq_analysis_pkg
//  Description : Shared constants, state encoding and bin unpack helper for
//                the frequency analysis datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package freq_analysis_pkg;

    localparam int N_BINS  = 16;
    localparam int COMP_W  = 16;
    localparam int IW      = $clog2(N_BINS);
    localparam int MAG_W   = 2 * COMP_W;
    localparam int BIN_W   = 2 * COMP_W;
    localparam int FRAME_W = N_BINS * BIN_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // One complex bin as it sits in the frame word: real in the upper half.
    typedef struct packed {
        logic signed [COMP_W-1:0] re;
        logic signed [COMP_W-1:0] im;
    } bin_t;

    // Extract bin k from a packed frame.
    function automatic bin_t unpack_bin(input logic [FRAME_W-1:0] frame,
                                        input logic [IW-1:0]      k);
        return bin_t'(frame[BIN_W * int'(k) +: BIN_W]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_peak_detector_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_peak_detector_if
//  Description : Frame input and peak result bundle between the FFT stage
//                and the peak detector.
//  Revision    : 1.0  initial release
// ============================================================================
interface fft_peak_detector_if;
    import freq_analysis_pkg::*;

    logic                fft_valid;
    logic [FRAME_W-1:0]  fft_d;
    logic                busy;
    logic                done;
    logic [IW-1:0]       freq;
    logic [MAG_W-1:0]    peak_pow;

    // FFT side: provides frames, observes results.
    modport master (
        output fft_valid, fft_d,
        input  busy, done, freq, peak_pow
    );

    // Detector side.
    modport slave (
        input  fft_valid, fft_d,
        output busy, done, freq, peak_pow
    );
endinterface
`default_nettype wire

// File: rtl/bin_mag_sq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_mag_sq
//  Description : Combinational magnitude-squared of one complex bin.
//                Worst case (-2^15)^2 * 2 = 2^31 fits the unsigned result.
//  Revision    : 1.0  initial release
// ============================================================================
module bin_mag_sq
    import freq_analysis_pkg::*;
(
    input  logic signed [COMP_W-1:0] re,
    input  logic signed [COMP_W-1:0] im,
    output logic        [MAG_W-1:0]  mag
);

    logic signed [MAG_W-1:0] re_sq;
    logic signed [MAG_W-1:0] im_sq;

    // Each square is non-negative and at most 2^30, so the signed products
    // can be summed as unsigned without losing the top bit.
    always_comb begin
        re_sq = re * re;
        im_sq = im * im;
        mag   = $unsigned(re_sq) + $unsigned(im_sq);
    end

endmodule
`default_nettype wire

// File: rtl/fft_peak_detector.sv
`default_nettype none
// ============================================================================
//  Module      : fft_peak_detector
//  Description : Captures one FFT frame, scans SCAN_BINS bins one per cycle
//                and reports the strongest bin index and its power.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_peak_detector
    import freq_analysis_pkg::*;
#(
    parameter int SCAN_BINS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    fft_peak_detector_if.slave        bus
);

    localparam logic [IW-1:0] LAST_IDX = IW'(SCAN_BINS - 1);

    state_t              state;
    state_t              state_nxt;
    logic                capture;
    logic                scan_last;

    logic [FRAME_W-1:0]  frame;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       run_idx;
    logic [MAG_W-1:0]    run_max;

    logic                busy;
    logic                done;
    logic [IW-1:0]       freq;
    logic [MAG_W-1:0]    peak_pow;

    bin_t                cur_bin;
    logic [MAG_W-1:0]    mag;
    logic                take;
    logic [MAG_W-1:0]    max_nxt;
    logic [IW-1:0]       idx_of_max_nxt;

    // Single magnitude unit shared across the scan via a mux on idx.
    assign cur_bin = unpack_bin(frame, idx);

    bin_mag_sq u_bin_mag_sq (
        .re  (cur_bin.re),
        .im  (cur_bin.im),
        .mag (mag)
    );

    // Running-max update: bin 0 seeds unconditionally; later bins need a
    // strictly larger power so ties keep the lowest index.
    always_comb begin
        take           = (idx == '0) || (mag > run_max);
        max_nxt        = take ? mag : run_max;
        idx_of_max_nxt = take ? idx : run_idx;
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        scan_last = 1'b0;
        case (state)
            IDLE: begin
                if (bus.fft_valid) begin
                    capture   = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (idx == LAST_IDX) begin
                    scan_last = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame buffer: loaded only on capture, deliberately not reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            frame <= bus.fft_d;
        end
    end

    // Scan counter, running maximum and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            run_idx  <= '0;
            run_max  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            freq     <= '0;
            peak_pow <= '0;
        end else begin
            done <= scan_last;
            if (capture) begin
                idx  <= '0;
                busy <= 1'b1;
            end
            if (state == SCAN) begin
                run_max <= max_nxt;
                run_idx <= idx_of_max_nxt;
                if (scan_last) begin
                    freq     <= idx_of_max_nxt;
                    peak_pow <= max_nxt;
                    busy     <= 1'b0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.freq     = freq;
    assign bus.peak_pow = peak_pow;

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_peak_detector
//  Description : Self-checking bench for fft_peak_detector with directed
//                corner frames, randomized frames and a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_peak_detector;
    import freq_analysis_pkg::*;

    localparam int SCAN_BINS = 16;

    logic clk;
    logic rst;

    fft_peak_detector_if bus ();

    fft_peak_detector #(.SCAN_BINS(SCAN_BINS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: power of every scanned bin, strongest wins, lowest index on ties.
    task automatic ref_peak(input logic [FRAME_W-1:0] f, output logic [IW-1:0] fq,
                            output logic [MAG_W-1:0] pw);
        longint best;
        longint re;
        longint im;
        longint m;
        logic [BIN_W-1:0] b;
        best = -1;
        fq   = '0;
        for (int k = 0; k < SCAN_BINS; k++) begin
            b  = f[BIN_W*k +: BIN_W];
            re = longint'($signed(b[BIN_W-1:COMP_W]));
            im = longint'($signed(b[COMP_W-1:0]));
            m  = re * re + im * im;
            if (m > best) begin
                best = m;
                fq   = IW'(k);
            end
        end
        pw = MAG_W'(best);
    endtask

    // Cycle-level expectation: frame accepted on an edge when no frame is in
    // flight; result appears SCAN_BINS edges later; reset clears everything.
    int               m_rem = 0;
    logic             m_done = 1'b0;
    logic [IW-1:0]    m_freq = '0;
    logic [MAG_W-1:0] m_pow = '0;
    logic [FRAME_W-1:0] m_frame;
    int               done_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_freq = '0;
            m_pow  = '0;
        end else begin
            m_done = 1'b0;
            if (m_rem == 0) begin
                if (bus.fft_valid) begin
                    m_frame = bus.fft_d;
                    m_rem   = SCAN_BINS;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    ref_peak(m_frame, m_freq, m_pow);
                    m_done = 1'b1;
                end
            end
        end
        #1;
        if (bus.done === 1'b1) done_cnt++;
        check("mon_done", 64'(bus.done), 64'(m_done));
        check("mon_busy", 64'(bus.busy), 64'(m_rem != 0));
        check("mon_freq", 64'(bus.freq), 64'(m_freq));
        check("mon_pow",  64'(bus.peak_pow), 64'(m_pow));
    end

    logic [FRAME_W-1:0] fr;

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [FRAME_W-1:0] rand_frame(input int mode);
        logic [FRAME_W-1:0] f;
        logic [COMP_W-1:0]  re;
        logic [COMP_W-1:0]  im;
        f = '0;
        for (int k = 0; k < N_BINS; k++) begin
            case (mode)
                0: begin re = COMP_W'($urandom); im = COMP_W'($urandom); end
                1: begin
                    re = COMP_W'($signed($urandom_range(0, 4)) - 2);
                    im = COMP_W'($signed($urandom_range(0, 4)) - 2);
                end
                default: begin
                    re = ($urandom_range(0, 5) == 0) ? COMP_W'($urandom) : '0;
                    im = ($urandom_range(0, 5) == 0) ? COMP_W'($urandom) : '0;
                end
            endcase
            f[BIN_W*k +: BIN_W] = {re, im};
        end
        return f;
    endfunction

    // One-cycle frame pulse; checks latency, pulse width and the reported peak.
    task automatic run_pulse(input string tag, input logic [FRAME_W-1:0] f,
                             input logic [IW-1:0] efreq, input logic [MAG_W-1:0] epow);
        int n;
        bus.fft_valid = 1'b1;
        bus.fft_d     = f;
        tick();
        bus.fft_valid = 1'b0;
        bus.fft_d     = rand_frame(0);
        check({tag, "_busy"}, 64'(bus.busy), 64'(1));
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            bus.fft_d = rand_frame(0);
            n++;
        end
        // Edges after the capture edge until done is visible.
        check({tag, "_lat"}, 64'(n), 64'(SCAN_BINS));
        check({tag, "_freq"}, 64'(bus.freq), 64'(efreq));
        check({tag, "_pow"}, 64'(bus.peak_pow), 64'(epow));
        check({tag, "_idle"}, 64'(bus.busy), 64'(0));
        tick();
        check({tag, "_pulse"}, 64'(bus.done), 64'(0));
        check({tag, "_hold"}, 64'(bus.freq), 64'(efreq));
    endtask

    initial begin
        int d0;
        int last_done_cyc;
        int cyc;
        logic [IW-1:0]    rf;
        logic [MAG_W-1:0] rp;

        rst           = 1'b1;
        bus.fft_valid = 1'b1;
        bus.fft_d     = rand_frame(0);
        repeat (3) begin
            tick();
            check("rst_busy", 64'(bus.busy), 64'(0));
            check("rst_done", 64'(bus.done), 64'(0));
            check("rst_freq", 64'(bus.freq), 64'(0));
            check("rst_pow",  64'(bus.peak_pow), 64'(0));
        end
        bus.fft_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Single peak.
        fr = '0;
        fr[BIN_W*5 +: BIN_W] = {16'h0100, 16'h0000};
        run_pulse("peak5", fr, 4'd5, 32'h0001_0000);

        // Negative extremes.
        fr = '0;
        fr[BIN_W*9 +: BIN_W] = {16'h8000, 16'h8000};
        fr[BIN_W*2 +: BIN_W] = {16'h7FFF, 16'h0000};
        run_pulse("extreme", fr, 4'd9, 32'h8000_0000);

        // Tie keeps lowest index.
        fr = '0;
        fr[BIN_W*3  +: BIN_W] = {16'h0010, 16'hFFF0};
        fr[BIN_W*12 +: BIN_W] = {16'h0010, 16'hFFF0};
        run_pulse("tie", fr, 4'd3, 32'h0000_0200);

        // All-zero frame still pulses done.
        run_pulse("zero", '0, 4'd0, 32'h0);

        // Abort mid-scan: reset once bin 7 is being processed.
        bus.fft_valid = 1'b1;
        bus.fft_d     = rand_frame(0);
        tick();
        bus.fft_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        d0  = done_cnt;
        repeat (2) tick();
        check("abort_busy", 64'(bus.busy), 64'(0));
        rst = 1'b0;
        repeat (20) tick();
        check("abort_nodone", 64'(done_cnt), 64'(d0));
        fr = '0;
        fr[BIN_W*14 +: BIN_W] = {16'h0000, 16'h0040};
        run_pulse("after_abort", fr, 4'd14, 32'h0000_1000);

        // Random single frames across value mixes, checked against the reference.
        for (int t = 0; t < 30; t++) begin
            fr = rand_frame(t % 3);
            ref_peak(fr, rf, rp);
            run_pulse("rand", fr, rf, rp);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Held fft_valid with data changing every cycle; done spacing must be
        // the minimum frame period.
        bus.fft_valid = 1'b1;
        last_done_cyc = -1;
        cyc = 0;
        d0  = done_cnt;
        for (int c = 0; c < 120; c++) begin
            bus.fft_d = rand_frame(c % 3);
            tick();
            cyc++;
            if (bus.done === 1'b1) begin
                if (last_done_cyc >= 0)
                    check("held_spacing", 64'(cyc - last_done_cyc), 64'(SCAN_BINS + 1));
                last_done_cyc = cyc;
            end
        end
        bus.fft_valid = 1'b0;
        check("held_count", 64'(done_cnt - d0 >= 6), 64'(1));
        repeat (SCAN_BINS + 4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
